// File: rtl/shift_reg_pkg.sv
// Shared definitions for the universal shift register: the mode encodings and their type.
package shift_reg_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_HOLD = 2'b00;
    localparam mode_t MODE_SHR  = 2'b01;
    localparam mode_t MODE_SHL  = 2'b10;
    localparam mode_t MODE_LOAD = 2'b11;

endpackage

// File: rtl/shift_reg_cell.sv
// One register bit: a 4:1 next-state mux (hold / left neighbour / right neighbour / load) and its flop.
module shift_reg_cell
    import shift_reg_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [1:0] mode,
    input  logic       left_nbr,
    input  logic       right_nbr,
    input  logic       load_bit,
    output logic       q
);

    // left_nbr feeds this bit on a right shift, right_nbr on a left shift
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else if (clr) begin
            q <= 1'b0;
        end else if (en) begin
            case (mode_t'(mode))
                MODE_SHR:  q <= left_nbr;
                MODE_SHL:  q <= right_nbr;
                MODE_LOAD: q <= load_bit;
                default:   q <= q;
            endcase
        end
    end

endmodule

// File: rtl/shift_reg_universal.sv
// Universal shift register: bidirectional serial in/out, parallel load/out, and a bit counter
// that pulses word_valid when a full WIDTH-bit serial word has been shifted in.
module shift_reg_universal
    import shift_reg_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sin_msb,
    input  logic             sin_lsb,
    input  logic [WIDTH-1:0] pdata,
    output logic [WIDTH-1:0] q,
    output logic             sout_lsb,
    output logic             sout_msb,
    output logic [CW-1:0]    bit_cnt,
    output logic             word_valid
);

    logic [WIDTH-1:0] shr_src;
    logic [WIDTH-1:0] shl_src;

    assign shr_src = {sin_msb, q[WIDTH-1:1]};
    assign shl_src = {q[WIDTH-2:0], sin_lsb};

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        shift_reg_cell u_cell (
            .clk       (clk),
            .rst       (rst),
            .clr       (clr),
            .en        (en),
            .mode      (mode),
            .left_nbr  (shr_src[i]),
            .right_nbr (shl_src[i]),
            .load_bit  (pdata[i]),
            .q         (q[i])
        );
    end

    assign sout_lsb = q[0];
    assign sout_msb = q[WIDTH-1];

    // Direction changes keep counting; only load, clr or reset restart a word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt    <= '0;
            word_valid <= 1'b0;
        end else if (clr) begin
            bit_cnt    <= '0;
            word_valid <= 1'b0;
        end else if (!en) begin
            word_valid <= 1'b0;
        end else begin
            case (mode_t'(mode))
                MODE_SHR, MODE_SHL: begin
                    if (bit_cnt == CW'(WIDTH - 1)) begin
                        bit_cnt    <= '0;
                        word_valid <= 1'b1;
                    end else begin
                        bit_cnt    <= bit_cnt + 1'b1;
                        word_valid <= 1'b0;
                    end
                end
                MODE_LOAD: begin
                    bit_cnt    <= '0;
                    word_valid <= 1'b0;
                end
                default: begin
                    word_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_reg_universal.sv
// Directed self-checking bench for shift_reg_universal (WIDTH = 8) with hand-computed expectations.
module tb_shift_reg_universal;

    logic       clk;
    logic       rst;
    logic       clr;
    logic       en;
    logic [1:0] mode;
    logic       sin_msb;
    logic       sin_lsb;
    logic [7:0] pdata;
    logic [7:0] q;
    logic       sout_lsb;
    logic       sout_msb;
    logic [2:0] bit_cnt;
    logic       word_valid;

    int errors = 0;
    int checks = 0;

    shift_reg_universal #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .en         (en),
        .mode       (mode),
        .sin_msb    (sin_msb),
        .sin_lsb    (sin_lsb),
        .pdata      (pdata),
        .q          (q),
        .sout_lsb   (sout_lsb),
        .sout_msb   (sout_msb),
        .bit_cnt    (bit_cnt),
        .word_valid (word_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, clock them in, and settle 1 ns past the edge
    task automatic applyStimulus(input logic c, input logic e, input logic [1:0] m,
                                 input logic smsb, input logic slsb, input logic [7:0] pd);
        clr     = c;
        en      = e;
        mode    = m;
        sin_msb = smsb;
        sin_lsb = slsb;
        pdata   = pd;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0]  shr_bits;
        logic [7:0]  shl_bits;
        logic [23:0] stream;
        int          pulses;
        int          pulse_at[$];

        shr_bits = 8'b1010_0101;
        shl_bits = 8'b1100_0011;
        stream   = {8'hE1, 8'h3C, 8'h96};

        rst = 1'b1; clr = 1'b0; en = 1'b0; mode = 2'b00;
        sin_msb = 1'b0; sin_lsb = 1'b0; pdata = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_q", q, 8'h00);
        checkOutput("reset_cnt", bit_cnt, 0);
        checkOutput("reset_wv", word_valid, 0);
        checkOutput("reset_sout_lsb", sout_lsb, 0);
        checkOutput("reset_sout_msb", sout_msb, 0);
        rst = 1'b0;

        // Reset mid-shift: three right shifts of 1, then asynchronous reset between edges
        repeat (3) applyStimulus(0, 1, 2'b01, 1, 0, 8'h00);
        checkOutput("pre_rst_q", q, 8'hE0);
        checkOutput("pre_rst_cnt", bit_cnt, 3);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_rst_q", q, 8'h00);
        checkOutput("async_rst_cnt", bit_cnt, 0);
        checkOutput("async_rst_wv", word_valid, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Shift right 1,0,1,0,0,1,0,1 -> 0xA5
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 1, 2'b01, shr_bits[7 - i], 0, 8'h00);
            if (i < 7) checkOutput($sformatf("shr_wv_%0d", i), word_valid, 0);
        end
        checkOutput("shr_q", q, 8'hA5);
        checkOutput("shr_wv", word_valid, 1);
        checkOutput("shr_cnt", bit_cnt, 0);
        applyStimulus(0, 1, 2'b00, 0, 0, 8'h00);
        checkOutput("hold_wv_drop", word_valid, 0);
        checkOutput("hold_q", q, 8'hA5);

        // Clear, then shift left 1,1,0,0,0,0,1,1 -> 0xC3
        applyStimulus(1, 0, 2'b00, 0, 0, 8'h00);
        checkOutput("clr_q", q, 8'h00);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("shl_sout_msb_%0d", i), sout_msb, 0);
            applyStimulus(0, 1, 2'b10, 0, shl_bits[7 - i], 8'h00);
        end
        checkOutput("shl_q", q, 8'hC3);
        checkOutput("shl_wv", word_valid, 1);

        // Load right after a completed word: pulse drops, counter restarts
        applyStimulus(0, 1, 2'b11, 0, 0, 8'h81);
        checkOutput("load_q", q, 8'h81);
        checkOutput("load_wv", word_valid, 0);
        checkOutput("load_cnt", bit_cnt, 0);
        checkOutput("load_sout_lsb", sout_lsb, 1);
        checkOutput("ld_shl_sout0", sout_msb, 1);
        applyStimulus(0, 1, 2'b10, 0, 0, 8'h00);
        checkOutput("ld_shl_sout1", sout_msb, 0);
        applyStimulus(0, 1, 2'b10, 0, 0, 8'h00);
        checkOutput("ld_shl_sout2", sout_msb, 0);
        applyStimulus(0, 1, 2'b10, 0, 0, 8'h00);
        checkOutput("ld_shl_q", q, 8'h08);
        checkOutput("ld_shl_cnt", bit_cnt, 3);
        repeat (4) applyStimulus(0, 1, 2'b10, 0, 0, 8'h00);
        checkOutput("ld_shl_wv_early", word_valid, 0);
        checkOutput("ld_shl_cnt7", bit_cnt, 7);
        applyStimulus(0, 1, 2'b10, 0, 0, 8'h00);
        checkOutput("ld_shl_wv", word_valid, 1);
        checkOutput("ld_shl_q_end", q, 8'h00);
        checkOutput("ld_shl_cnt_wrap", bit_cnt, 0);

        // Enable gating: en=0 with mode=shift right holds everything
        applyStimulus(0, 1, 2'b11, 0, 0, 8'h3C);
        repeat (2) applyStimulus(0, 1, 2'b01, 0, 0, 8'h00);
        checkOutput("gate_pre_q", q, 8'h0F);
        checkOutput("gate_pre_cnt", bit_cnt, 2);
        repeat (4) applyStimulus(0, 0, 2'b01, 1, 1, 8'hFF);
        checkOutput("gate_q", q, 8'h0F);
        checkOutput("gate_cnt", bit_cnt, 2);
        checkOutput("gate_wv", word_valid, 0);

        // Direction change mid-word keeps the count
        applyStimulus(0, 1, 2'b10, 0, 1, 8'h00);
        checkOutput("dirchg_q", q, 8'h1F);
        checkOutput("dirchg_cnt", bit_cnt, 3);

        // clr wins over an enabled shift; load follows; then 24 continuous shifts
        applyStimulus(1, 1, 2'b10, 1, 1, 8'hFF);
        checkOutput("mix_clr_q", q, 8'h00);
        checkOutput("mix_clr_cnt", bit_cnt, 0);
        applyStimulus(0, 1, 2'b11, 0, 0, 8'h5A);
        checkOutput("mix_load_q", q, 8'h5A);
        checkOutput("mix_load_sout_lsb", sout_lsb, 0);
        pulses = 0;
        for (int j = 0; j < 24; j++) begin
            applyStimulus(0, 1, 2'b01, stream[j], 0, 8'h00);
            checkOutput($sformatf("stream_wv_%0d", j), word_valid, ((j + 1) % 8 == 0) ? 1 : 0);
            if (word_valid) begin
                pulses++;
                pulse_at.push_back(j);
                checkOutput($sformatf("stream_word_%0d", j / 8), q, stream[(j / 8) * 8 +: 8]);
            end
        end
        checkOutput("stream_pulses", pulses, 3);
        if (pulse_at.size() == 3) begin
            checkOutput("stream_gap01", pulse_at[1] - pulse_at[0], 8);
            checkOutput("stream_gap12", pulse_at[2] - pulse_at[1], 8);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
